// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state, requester ids and constants for the unified memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam logic       REQ_IF  = 1'b0;
    localparam logic       REQ_MEM = 1'b1;
    localparam logic [1:0] BE_ALL  = 2'b11;

    // MEM has priority unless the starvation counter forces IF through.
    function automatic logic pick_winner(input logic if_v, input logic m_v, input logic force_if);
        if (if_v && (!m_v || force_if)) begin
            return REQ_IF;
        end
        return REQ_MEM;
    endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// rtl/mem_arb_starve_ctr.sv - saturating count of MEM grants taken while IF waits
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int MAX_IF_WAIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic grant_mem_if_wait,
    input  logic grant_if,
    output logic force_if
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_IF_WAIT);

    logic [3:0] starve_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= 4'd0;
        end else if (grant_if) begin
            starve_cnt <= 4'd0;
        end else if (grant_mem_if_wait && (starve_cnt != MAX_CNT)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign force_if = (starve_cnt == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one fixed-latency single-port memory between fetch and load/store
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int LATENCY     = 1,
    parameter int MAX_IF_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              m_req,
    input  logic              m_we,
    input  logic [1:0]        m_be,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_wdata,
    output logic              m_ack,
    output logic [DATA_W-1:0] m_rdata,
    output logic              m_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [1:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] LAT_INIT = 3'(LATENCY);

    arb_state_t state;
    logic [2:0] lat_cnt;
    logic       cmd_id;
    logic       if_v;
    logic       m_v;
    logic       grant;
    logic       win;
    logic       force_if;

    // A requester being acked this cycle is still holding its old request.
    assign if_v  = if_req & ~if_ack;
    assign m_v   = m_req & ~m_ack;
    assign grant = (state == IDLE) & (if_v | m_v);
    assign win   = pick_winner(if_v, m_v, force_if);

    assign if_stall = rst & if_req & ~if_ack;
    assign m_stall  = rst & m_req & ~m_ack;

    mem_arb_starve_ctr #(
        .MAX_IF_WAIT(MAX_IF_WAIT)
    ) u_starve (
        .clk              (clk),
        .rst              (rst),
        .grant_mem_if_wait(grant & (win == REQ_MEM) & if_req),
        .grant_if         (grant & (win == REQ_IF)),
        .force_if         (force_if)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lat_cnt   <= 3'd0;
            cmd_id    <= REQ_IF;
            if_ack    <= 1'b0;
            m_ack     <= 1'b0;
            if_rdata  <= '0;
            m_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 2'b00;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 2'b00;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            m_ack     <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        cmd_id <= win;
                        state  <= ISSUE;
                        mem_en <= 1'b1;
                        if (win == REQ_IF) begin
                            mem_addr <= if_addr;
                            mem_be   <= BE_ALL;
                        end else begin
                            mem_addr  <= m_addr;
                            mem_we    <= m_we;
                            mem_be    <= m_we ? m_be : BE_ALL;
                            mem_wdata <= m_wdata;
                        end
                    end
                end
                ISSUE: begin
                    lat_cnt <= LAT_INIT;
                    state   <= WAIT;
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 3'd1;
                    if (lat_cnt == 3'd1) begin
                        state <= IDLE;
                        if (cmd_id == REQ_IF) begin
                            if_rdata <= mem_rdata;
                            if_ack   <= 1'b1;
                        end else begin
                            m_rdata <= mem_rdata;
                            m_ack   <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        if_req, m_req, m_we;
    logic [15:0] if_addr, m_addr, m_wdata;
    logic [1:0]  m_be;
    logic        if_ack, if_stall, m_ack, m_stall, mem_en, mem_we;
    logic [15:0] if_rdata, m_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_be;

    logic        b_if_req, b_m_req, b_m_we;
    logic [15:0] b_if_addr, b_m_addr, b_m_wdata;
    logic [1:0]  b_m_be;
    logic        b_if_ack, b_if_stall, b_m_ack, b_m_stall, b_mem_en, b_mem_we;
    logic [15:0] b_if_rdata, b_m_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [1:0]  b_mem_be;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(1), .MAX_IF_WAIT(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .m_stall(m_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(4), .MAX_IF_WAIT(1)) dut4 (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata), .if_stall(b_if_stall),
        .m_req(b_m_req), .m_we(b_m_we), .m_be(b_m_be), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
        .m_ack(b_m_ack), .m_rdata(b_m_rdata), .m_stall(b_m_stall),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    function automatic logic [15:0] mem_init(input int i);
        if (i == 16'h10) return 16'h1234;
        if (i == 16'h20) return 16'h5A5A;
        if (i == 16'h30) return 16'h0777;
        if (i == 16'h40) return 16'h00A5;
        return 16'(i * 40503) ^ 16'h5A3C;
    endfunction

    // Behavioural memories: read data appears LATENCY cycles after the mem_en cycle.
    logic [15:0] mem_a [0:255];
    logic [15:0] pipe_a [0:7];
    logic        ld_a = 1'b0;
    always @(posedge clk) begin
        for (int k = 7; k > 0; k--) pipe_a[k] <= pipe_a[k-1];
        pipe_a[0] <= mem_en ? mem_a[mem_addr[7:0]] : 16'hDEAD;
        if (!ld_a) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= mem_init(i);
            ld_a <= 1'b1;
        end else if (mem_en && mem_we) begin
            if (mem_be[0]) mem_a[mem_addr[7:0]][7:0] <= mem_wdata[7:0];
            if (mem_be[1]) mem_a[mem_addr[7:0]][15:8] <= mem_wdata[15:8];
        end
    end
    assign mem_rdata = pipe_a[0];

    logic [15:0] b_mem [0:255];
    logic [15:0] b_pipe [0:7];
    logic        ld_b = 1'b0;
    always @(posedge clk) begin
        for (int k = 7; k > 0; k--) b_pipe[k] <= b_pipe[k-1];
        b_pipe[0] <= b_mem_en ? b_mem[b_mem_addr[7:0]] : 16'hDEAD;
        if (!ld_b) begin
            for (int i = 0; i < 256; i++) b_mem[i] <= mem_init(i);
            ld_b <= 1'b1;
        end else if (b_mem_en && b_mem_we) begin
            if (b_mem_be[0]) b_mem[b_mem_addr[7:0]][7:0] <= b_mem_wdata[7:0];
            if (b_mem_be[1]) b_mem[b_mem_addr[7:0]][15:8] <= b_mem_wdata[15:8];
        end
    end
    assign b_mem_rdata = b_pipe[3];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic ir; logic [15:0] ia; logic mr; logic mw; logic [1:0] mb; logic [15:0] ma; logic [15:0] md;
        logic e_ia; logic e_ma; logic e_is; logic e_ms; logic e_en; logic e_we; logic [1:0] e_be;
        logic [15:0] e_addr; logic [15:0] e_wd; logic [1:0] rs; logic [15:0] rd;
    } vec_t;
    vec_t vecs [18];

    // Random-phase reference: transaction scheduler driven by the arbitration rules.
    localparam int LAT = 1;
    localparam int MAXW = 3;
    int t, free_at, issue_at, if_ack_at, m_ack_at, starve;
    logic iss_we;
    logic [1:0] iss_be;
    logic [15:0] iss_addr, iss_wd, last_addr, exp_if_rd, exp_m_rd;
    logic m_ld, seen_if_ack, seen_m_ack;
    logic e_ia, e_ma, e_en, ifv, mv, take_if;
    int ack_cyc, en_cyc, en_cnt;
    logic got_ack;
    logic [15:0] rd;

    initial begin
        {if_req, m_req, m_we, if_addr, m_addr, m_wdata, m_be} = '0;
        {b_if_req, b_m_req, b_m_we, b_if_addr, b_m_addr, b_m_wdata, b_m_be} = '0;

        vecs[0]  = '{1'b1,16'h0010,1'b0,1'b0,2'b00,16'h0000,16'h0000, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,16'h0000,16'h0000,2'd0,16'h0000};
        vecs[1]  = '{1'b1,16'h0010,1'b0,1'b0,2'b00,16'h0000,16'h0000, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b11,16'h0010,16'h0000,2'd0,16'h0000};
        vecs[2]  = '{1'b1,16'h0010,1'b0,1'b0,2'b00,16'h0000,16'h0000, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,16'h0010,16'h0000,2'd0,16'h0000};
        vecs[3]  = '{1'b1,16'h0010,1'b0,1'b0,2'b00,16'h0000,16'h0000, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,16'h0010,16'h0000,2'd1,16'h1234};
        vecs[4]  = '{1'b0,16'h0000,1'b0,1'b0,2'b00,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,16'h0010,16'h0000,2'd0,16'h0000};
        vecs[5]  = '{1'b1,16'h0020,1'b1,1'b1,2'b01,16'h0200,16'hBEEF, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,16'h0010,16'h0000,2'd0,16'h0000};
        vecs[6]  = '{1'b1,16'h0020,1'b1,1'b1,2'b01,16'h0200,16'hBEEF, 1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,2'b01,16'h0200,16'hBEEF,2'd0,16'h0000};
        vecs[7]  = '{1'b1,16'h0020,1'b1,1'b1,2'b01,16'h0200,16'hBEEF, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,16'h0200,16'h0000,2'd0,16'h0000};
        vecs[8]  = '{1'b1,16'h0020,1'b1,1'b1,2'b01,16'h0200,16'hBEEF, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,16'h0200,16'h0000,2'd0,16'h0000};
        vecs[9]  = '{1'b1,16'h0020,1'b0,1'b0,2'b00,16'h0000,16'h0000, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b11,16'h0020,16'h0000,2'd0,16'h0000};
        vecs[10] = '{1'b1,16'h0020,1'b0,1'b0,2'b00,16'h0000,16'h0000, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,16'h0020,16'h0000,2'd0,16'h0000};
        vecs[11] = '{1'b1,16'h0020,1'b0,1'b0,2'b00,16'h0000,16'h0000, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,16'h0020,16'h0000,2'd1,16'h5A5A};
        vecs[12] = '{1'b0,16'h0000,1'b1,1'b0,2'b11,16'h0030,16'h0000, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,16'h0020,16'h0000,2'd0,16'h0000};
        vecs[13] = '{1'b0,16'h0000,1'b1,1'b0,2'b11,16'h0030,16'h0000, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b11,16'h0030,16'h0000,2'd0,16'h0000};
        vecs[14] = '{1'b0,16'h0000,1'b1,1'b0,2'b11,16'h0030,16'h0000, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,16'h0030,16'h0000,2'd0,16'h0000};
        vecs[15] = '{1'b0,16'h0000,1'b1,1'b0,2'b11,16'h0030,16'h0000, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,16'h0030,16'h0000,2'd2,16'h0777};
        vecs[16] = '{1'b0,16'h0000,1'b0,1'b0,2'b00,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,16'h0030,16'h0000,2'd0,16'h0000};
        vecs[17] = '{1'b0,16'h0000,1'b0,1'b0,2'b00,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,16'h0030,16'h0000,2'd0,16'h0000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {if_ack, m_ack, if_rdata, m_rdata, mem_en, mem_we, mem_be, mem_addr, mem_wdata, if_stall, m_stall}, '0);
        chk("reset_outs_b", {b_if_ack, b_m_ack, b_mem_en, b_mem_we, b_mem_be, b_mem_addr, b_mem_wdata}, '0);
        rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
            if_req = vecs[i].ir; if_addr = vecs[i].ia; m_req = vecs[i].mr; m_we = vecs[i].mw;
            m_be = vecs[i].mb; m_addr = vecs[i].ma; m_wdata = vecs[i].md;
            @(negedge clk);
            chk($sformatf("vec%0d.if_ack", i), if_ack, vecs[i].e_ia);
            chk($sformatf("vec%0d.m_ack", i), m_ack, vecs[i].e_ma);
            chk($sformatf("vec%0d.if_stall", i), if_stall, vecs[i].e_is);
            chk($sformatf("vec%0d.m_stall", i), m_stall, vecs[i].e_ms);
            chk($sformatf("vec%0d.mem_cmd", i), {mem_en, mem_we, mem_be, mem_addr, mem_wdata},
                {vecs[i].e_en, vecs[i].e_we, vecs[i].e_be, vecs[i].e_addr, vecs[i].e_wd});
            if (vecs[i].rs == 2'd1) chk($sformatf("vec%0d.if_rdata", i), if_rdata, vecs[i].rd);
            if (vecs[i].rs == 2'd2) chk($sformatf("vec%0d.m_rdata", i), m_rdata, vecs[i].rd);
        end

        // Reset asserted while a fetch is in WAIT.
        @(posedge clk); #1; if_req = 1'b1; if_addr = 16'h0010;
        @(posedge clk);
        @(posedge clk); #3; rst = 1'b0; #1;
        chk("rst_mid_outs", {if_ack, m_ack, if_rdata, m_rdata, mem_en, mem_we, mem_be, mem_addr, mem_wdata, if_stall, m_stall}, '0);
        if_req = 1'b0;
        @(negedge clk); rst = 1'b1;
        got_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (if_ack || m_ack || mem_en) got_ack = 1'b1;
        end
        chk("rst_no_stale", got_ack, 1'b0);
        @(posedge clk); #1; if_req = 1'b1; if_addr = 16'h0030;
        ack_cyc = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (if_ack) begin ack_cyc = k; break; end
        end
        chk("rst_fresh_ack_cycle", ack_cyc, 3);
        chk("rst_fresh_rdata", if_rdata, 16'h0777);
        @(posedge clk); #1; if_req = 1'b0;

        // LATENCY=4 load.
        en_cnt = 0; en_cyc = -1; ack_cyc = -1; got_ack = 1'b0; rd = '0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                b_m_req = 1'b1; b_m_we = 1'b0; b_m_be = 2'b11; b_m_addr = 16'h0040;
            end else if (got_ack) begin
                b_m_req = 1'b0;
            end
            @(negedge clk);
            if (b_mem_en) begin en_cnt++; en_cyc = k; end
            if (b_m_ack && !got_ack) begin ack_cyc = k; rd = b_m_rdata; got_ack = 1'b1; end
        end
        chk("lat4_ack_cycle", ack_cyc, 6);
        chk("lat4_rdata", rd, 16'h00A5);
        chk("lat4_en_count", en_cnt, 1);
        chk("lat4_en_cycle", en_cyc, 1);

        // MAX_IF_WAIT=1: one MEM grant while IF waits forces the next tie to IF.
        @(posedge clk); #1; b_if_req = 1'b1; b_if_addr = 16'h0050;
        @(posedge clk); #1; b_m_req = 1'b1; b_m_we = 1'b0; b_m_be = 2'b11; b_m_addr = 16'h0060;
        for (int k = 0; k < 20; k++) begin @(negedge clk); if (b_if_ack) break; end
        chk("starve_if1_ack", b_if_ack, 1'b1);
        @(posedge clk); #1; b_if_req = 1'b0;
        for (int k = 0; k < 20; k++) begin @(negedge clk); if (b_m_ack) break; end
        chk("starve_m1_ack", b_m_ack, 1'b1);
        chk("starve_m1_rdata", b_m_rdata, b_mem[8'h60]);
        @(posedge clk); #1; b_m_addr = 16'h0061; b_if_req = 1'b1; b_if_addr = 16'h0051;
        for (int k = 0; k < 20; k++) begin @(negedge clk); if (b_mem_en) break; end
        chk("starve_force_addr", b_mem_addr, 16'h0051);
        chk("starve_force_we", b_mem_we, 1'b0);
        for (int k = 0; k < 20; k++) begin @(negedge clk); if (b_if_ack) break; end
        chk("starve_if2_ack", b_if_ack, 1'b1);
        @(posedge clk); #1; b_if_req = 1'b0;
        for (int k = 0; k < 20; k++) begin @(negedge clk); if (b_m_ack) break; end
        chk("starve_m2_ack", b_m_ack, 1'b1);
        chk("starve_m2_rdata", b_m_rdata, b_mem[8'h61]);
        @(posedge clk); #1; b_m_req = 1'b0;

        // Randomized traffic against the scheduler model.
        @(negedge clk); rst = 1'b0;
        {if_req, m_req} = 2'b00;
        @(negedge clk); @(negedge clk); rst = 1'b1;
        free_at = 0; issue_at = -1; if_ack_at = -1; m_ack_at = -1; starve = 0;
        last_addr = '0; seen_if_ack = 1'b0; seen_m_ack = 1'b0; m_ld = 1'b0;
        iss_we = 1'b0; iss_be = 2'b00; iss_addr = '0; iss_wd = '0; exp_if_rd = '0; exp_m_rd = '0;
        for (t = 0; t < 400; t++) begin
            @(posedge clk); #1;
            if (!if_req || seen_if_ack) begin
                if_req = ($urandom_range(0, 2) != 0);
                if_addr = 16'($urandom);
            end
            if (!m_req || seen_m_ack) begin
                m_req = ($urandom_range(0, 2) != 0);
                m_we = 1'($urandom_range(0, 1));
                m_be = 2'($urandom_range(1, 3));
                m_addr = 16'($urandom);
                m_wdata = 16'($urandom);
            end
            @(negedge clk);
            e_ia = (t == if_ack_at);
            e_ma = (t == m_ack_at);
            e_en = (t == issue_at);
            if (e_en) last_addr = iss_addr;
            chk($sformatf("rnd%0d.if_ack", t), if_ack, e_ia);
            chk($sformatf("rnd%0d.m_ack", t), m_ack, e_ma);
            chk($sformatf("rnd%0d.stalls", t), {if_stall, m_stall}, {if_req & ~e_ia, m_req & ~e_ma});
            chk($sformatf("rnd%0d.mem_en", t), mem_en, e_en);
            chk($sformatf("rnd%0d.mem_addr", t), mem_addr, last_addr);
            if (e_en) begin
                chk($sformatf("rnd%0d.mem_we_be", t), {mem_we, mem_be}, {iss_we, iss_be});
                if (iss_we) chk($sformatf("rnd%0d.mem_wdata", t), mem_wdata, iss_wd);
            end else begin
                chk($sformatf("rnd%0d.mem_idle", t), {mem_we, mem_be, mem_wdata}, '0);
            end
            if (e_ia) chk($sformatf("rnd%0d.if_rdata", t), if_rdata, exp_if_rd);
            if (e_ma && m_ld) chk($sformatf("rnd%0d.m_rdata", t), m_rdata, exp_m_rd);
            if (t >= free_at) begin
                ifv = if_req && !e_ia;
                mv = m_req && !e_ma;
                if (ifv || mv) begin
                    take_if = ifv && (!mv || starve == MAXW);
                    issue_at = t + 1;
                    free_at = t + LAT + 2;
                    if (take_if) begin
                        starve = 0;
                        iss_we = 1'b0; iss_be = 2'b11; iss_addr = if_addr; iss_wd = '0;
                        if_ack_at = t + LAT + 2;
                        exp_if_rd = mem_a[if_addr[7:0]];
                    end else begin
                        if (if_req && starve < MAXW) starve++;
                        iss_we = m_we; iss_be = m_we ? m_be : 2'b11; iss_addr = m_addr; iss_wd = m_wdata;
                        m_ack_at = t + LAT + 2;
                        m_ld = !m_we;
                        exp_m_rd = mem_a[m_addr[7:0]];
                    end
                end
            end
            seen_if_ack = if_ack;
            seen_m_ack = m_ack;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Replaces the separate instruction and data memories once they are merged.
- Runs a registered issue/wait/acknowledge sequence against a fixed-latency memory.
- MEM has priority; a starvation counter guarantees IF forward progress.
- Drives per-stage stall outputs that feed the pipeline hazard logic.

Parameters:
- ADDR_W, 16, address width for both requesters and the memory.
- DATA_W, 16, data width (two bytes).
- LATENCY, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..7.
- MAX_IF_WAIT, 3, consecutive MEM grants allowed while IF is waiting before IF is forced to win; legal range 1..15.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst, in, 1, asynchronous active-low reset.
- if_req, in, 1, fetch request; held until if_ack.
- if_addr, in, ADDR_W, fetch address; stable while if_req is high.
- if_ack, out, 1, one-cycle pulse; if_rdata is valid in the same cycle.
- if_rdata, out, DATA_W, fetched instruction word.
- if_stall, out, 1, equals if_req & ~if_ack (combinational).
- m_req, in, 1, MEM-stage access request; held until m_ack.
- m_we, in, 1, 1 = store, 0 = load.
- m_be, in, 2, byte enables for stores; bit0 = [7:0], bit1 = [15:8].
- m_addr, in, ADDR_W, data address.
- m_wdata, in, DATA_W, store data.
- m_ack, out, 1, one-cycle completion pulse.
- m_rdata, out, DATA_W, load data, valid with m_ack.
- m_stall, out, 1, equals m_req & ~m_ack (combinational).
- mem_en, out, 1, memory access strobe; exactly one cycle per access.
- mem_we, out, 1, write enable, qualified by mem_en.
- mem_be, out, 2, byte enables; forced to 2'b11 on reads.
- mem_addr, out, ADDR_W, memory address.
- mem_wdata, out, DATA_W, memory write data.
- mem_rdata, in, DATA_W, memory read data, valid LATENCY cycles after the mem_en cycle.

Behaviour:
- Reset values: all outputs 0; state IDLE; starvation counter 0; latency counter 0. Reset asserted mid-access returns to IDLE immediately and abandons the access; no ack is issued.
- State IDLE:
  - Requesters whose ack is high this cycle are masked out of arbitration, so a held request is not re-granted.
  - Winner selection: if only one unmasked request, it wins. If both, MEM wins unless starve_cnt == MAX_IF_WAIT, in which case IF wins.
  - Winner id, address, we, be and wdata are registered. IF is forced to we = 0 and be = 2'b11.
  - Next state is ISSUE. With no request, stay in IDLE.
- State ISSUE (one cycle):
  - mem_en = 1 and the registered command drives the mem_* outputs.
  - Load lat_cnt = LATENCY; go to WAIT.
- State WAIT:
  - lat_cnt decrements each cycle.
  - When lat_cnt == 1, capture mem_rdata into the winner's rdata register (also for stores; value is don't-care), set the winner's ack for the next cycle, and go to IDLE.
- Ack pulse:
  - The ack is high for exactly one cycle, coinciding with the IDLE cycle.
  - rdata holds its value until the next capture for that requester.
- Latency: request sampled in IDLE at cycle 0 → mem_en at cycle 1 → ack at cycle LATENCY+2. With LATENCY=1, ack is at cycle 3.
- Back-to-back: the IDLE cycle that carries one requester's ack can grant the other requester. Throughput is one access per LATENCY+2 cycles.
- Starvation counter:
  - Increments (saturating at MAX_IF_WAIT) on each MEM grant made while if_req is high.
  - Clears on any IF grant.
  - Holds when if_req is low.
- mem_* outputs are 0 outside ISSUE except mem_addr, which holds its last value.
- Requests that drop before ack are a protocol violation; behaviour is undefined, and the bench must not generate them.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state enum: IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2;
  - requester id constants: REQ_IF = 1'b0, REQ_MEM = 1'b1;
  - the read byte-enable constant BE_ALL = 2'b11.
- One sub-module, mem_arb_starve_ctr: the saturating starvation counter. Inputs: grant-MEM-while-IF-waiting, grant-IF. Output: force_if.

Test Plan:
- Lone fetch: if_req=1, if_addr=0x0010, memory returns 0x1234 (LATENCY=1) → mem_en at cycle 1 with addr 0x0010 and we=0; if_ack and if_rdata=0x1234 at cycle 3; if_stall high for cycles 0–2.
- Simultaneous requests: if_req plus m_req store to 0x0200, wdata 0xBEEF, be=2'b01 → MEM is issued first with mem_be=01 and m_ack at cycle 3; IF is granted in cycle 3, has mem_en at cycle 4 and if_ack at cycle 6.
- Starvation: MAX_IF_WAIT=3, if_req held, m_req re-asserted each cycle after m_ack → exactly 3 MEM accesses, then an IF access, then starve_cnt reads 0.
- Latency sweep: LATENCY=4, load from 0x0040 returning 0x00A5 → m_ack at cycle 6 with m_rdata=0x00A5; exactly one mem_en pulse.
- Reset mid-access: rst low during WAIT → all outputs 0 within the same cycle; after release, a fresh if_req completes normally and no stale ack appears.
- Held request not re-granted: after m_ack, m_req stays high for the ack cycle only → no second mem_en for MEM.
